// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types and constants for the HI/LO divide stage.
// Revision : 1.0
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DBZ_LO = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/udiv_core.sv
`default_nettype none
// ============================================================================
// Module   : udiv_core
// Brief    : Iterative restoring unsigned divider, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module udiv_core
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done
);

    localparam int CNT_W = $clog2(ITER + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] src_rem;
    logic [WIDTH-1:0] src_quo;
    logic [WIDTH-1:0] src_dvs;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    // The first iteration runs on the start edge itself, so ITER edges
    // complete the divide and done is visible ITER cycles after start.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? a  : quo_q;
        src_dvs  = start ? b  : dvs_q;
        trial    = {src_rem, src_quo[WIDTH-1]};
        diff     = trial - {1'b0, src_dvs};
        ge       = ~diff[WIDTH];
        step_rem = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        step_quo = {src_quo[WIDTH-2:0], ge};
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = step_rem;
            quo_d = step_quo;
            dvs_d = b;
            cnt_d = CNT_W'(ITER - 1);
        end else if (cnt_q != '0) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q    = quo_q;
    assign r    = rem_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_hilo_ctrl
// Brief    : DIV/DIVU sequencing, sign fix-up and HI/LO commit with read stall.
// Revision : 1.0
// ============================================================================
module div_hilo_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             signed_q, signed_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             core_start;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;
    logic             core_done;

    // Negating the most negative value wraps to itself, which is the correct
    // unsigned magnitude, so no extra bit is carried into the core.
    always_comb begin
        mag_a = (signed_q && dividend_q[WIDTH-1]) ? -dividend_q : dividend_q;
        mag_b = (signed_q && divisor_q[WIDTH-1])  ? -divisor_q  : divisor_q;
    end

    udiv_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (core_start),
        .a     (mag_a),
        .b     (mag_b),
        .q     (core_q),
        .r     (core_r),
        .done  (core_done)
    );

    always_comb begin
        state_d       = state_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        signed_d      = signed_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        div_by_zero_d = div_by_zero_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        core_start    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d    = dividend;
                    divisor_d     = divisor;
                    signed_d      = is_signed;
                    div_by_zero_d = 1'b0;
                    state_d       = PREP;
                end
            end
            PREP: begin
                neg_quo_d = signed_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
                neg_rem_d = signed_q & dividend_q[WIDTH-1];
                if (divisor_q == '0) begin
                    div_by_zero_d = 1'b1;
                    state_d       = FIX;
                end else begin
                    core_start = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (core_done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (div_by_zero_q) begin
                    lo_d = WIDTH'(DBZ_LO);
                    hi_d = dividend_q;
                end else begin
                    lo_d = neg_quo_q ? -core_q : core_q;
                    hi_d = neg_rem_q ? -core_r : core_r;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            dividend_q    <= '0;
            divisor_q     <= '0;
            signed_q      <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            state_q       <= state_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            signed_q      <= signed_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            div_by_zero_q <= div_by_zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign stall       = rd_req & busy_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
`default_nettype wire
